// File: rtl/mem_access.sv
// Memory-access stage: issues one valid/ready data-memory request per instruction,
// returns the writeback bundle and branch redirect. Optional: MEM_ALIGN_CHECK_EN.
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  input  logic [4:0]  write_reg_in,
  input  logic        writef_in,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] alu_result,
  input  logic        branch_in,
  input  logic [31:0] branch_addr_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        busy,
  output logic        done,
  output logic        reg_write_out,
  output logic [4:0]  write_reg_out,
  output logic        writef_out,
  output logic [31:0] reg_write_data,
  output logic        branch_out,
  output logic [31:0] branch_addr_out,
  output logic        err
);

  // state | meaning
  // IDLE  | waiting for core state 3
  // REQ   | dmem_req asserted, waiting for dmem_ready
  // WAIT  | read accepted, waiting for dmem_rvalid
  // DONE  | one-cycle done pulse, writeback outputs valid
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} fsm_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  fsm_t state_q, state_d;

  logic        start, access_in, misalign_in;
  logic        rd_q, wr_q, rw_q, wf_q, br_q;
  logic [4:0]  wreg_q;
  logic [31:0] addr_q, wdata_q, alu_q, braddr_q;
  logic [CW-1:0] cnt_q, cnt_inc;
  logic        timeout_hit;
  logic        wb_load, wb_we, wb_err;
  logic [31:0] wb_data;

  assign start     = (state_q == IDLE) && (state == 3'd3);
  assign access_in = mem_read_in | mem_write_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_in = (mem_addr[1:0] != 2'b00);
`else
  assign misalign_in = 1'b0;
`endif

  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the value to load into the writeback registers on DONE entry.
  always_comb begin
    state_d = state_q;
    wb_load = 1'b0;
    wb_we   = 1'b0;
    wb_err  = 1'b0;
    wb_data = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (access_in && !misalign_in) begin
            state_d = REQ;
          end else begin
            state_d = DONE;
            wb_load = 1'b1;
            if (access_in) begin
              wb_err = 1'b1;
            end else begin
              wb_we   = reg_write_in;
              wb_data = alu_result;
            end
          end
        end
      end
      REQ: begin
        if (dmem_ready) begin
          if (rd_q) begin
            state_d = WAIT;
          end else begin
            state_d = DONE;
            wb_load = 1'b1;
            wb_we   = rw_q & ~wr_q;
            wb_data = alu_q;
          end
        end else if (timeout_hit) begin
          state_d = DONE;
          wb_load = 1'b1;
          wb_err  = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_d = DONE;
          wb_load = 1'b1;
          wb_we   = rw_q & ~wr_q;
          wb_data = dmem_rdata;
        end else if (timeout_hit) begin
          state_d = DONE;
          wb_load = 1'b1;
          wb_err  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_req   = (state_q == REQ);
    dmem_we    = wr_q & ~rd_q;
    dmem_addr  = addr_q;
    dmem_wdata = wdata_q;
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q            <= 1'b0;
      wr_q            <= 1'b0;
      rw_q            <= 1'b0;
      wf_q            <= 1'b0;
      br_q            <= 1'b0;
      wreg_q          <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      alu_q           <= '0;
      braddr_q        <= '0;
      cnt_q           <= '0;
      reg_write_out   <= 1'b0;
      write_reg_out   <= '0;
      writef_out      <= 1'b0;
      reg_write_data  <= '0;
      branch_out      <= 1'b0;
      branch_addr_out <= '0;
      err             <= 1'b0;
    end else begin
      if (start) begin
        rd_q     <= mem_read_in;
        wr_q     <= mem_write_in;
        rw_q     <= reg_write_in;
        wf_q     <= writef_in;
        br_q     <= branch_in;
        wreg_q   <= write_reg_in;
        addr_q   <= mem_addr;
        wdata_q  <= mem_write_data;
        alu_q    <= alu_result;
        braddr_q <= branch_addr_in;
      end

      if (state_q == IDLE && state_d == REQ)
        cnt_q <= '0;
      else if (state_q == REQ || state_q == WAIT)
        cnt_q <= cnt_inc;

      // A start that goes straight to DONE has not latched yet; take the inputs.
      if (wb_load) begin
        reg_write_out  <= wb_we;
        reg_write_data <= wb_data;
        if (state_q == IDLE) begin
          write_reg_out   <= write_reg_in;
          writef_out      <= writef_in;
          branch_out      <= branch_in;
          branch_addr_out <= branch_addr_in;
        end else begin
          write_reg_out   <= wreg_q;
          writef_out      <= wf_q;
          branch_out      <= br_q;
          branch_addr_out <= braddr_q;
        end
      end

      if (wb_err || (start && mem_read_in && mem_write_in))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected writeback bundles,
// per-instance monitors pop and compare on every done pulse.
module tb_mem_access;

  typedef struct {
    int          done_cyc;
    int          reqs;
    logic        rw;
    logic [4:0]  wreg;
    logic        wf;
    logic [31:0] data;
    logic        br;
    logic [31:0] braddr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state_a, state_b;
  logic        mem_read_in, mem_write_in, reg_write_in, writef_in, branch_in;
  logic [4:0]  write_reg_in;
  logic [31:0] mem_addr, mem_write_data, alu_result, branch_addr_in;
  logic        ready_a, rvalid_a, ready_b, rvalid_b;
  logic [31:0] rdata;

  logic        req_a, we_a, busy_a, done_a, rwo_a, wfo_a, bro_a, err_a;
  logic [31:0] addr_a, wdata_a, rwd_a, bra_a;
  logic [4:0]  wro_a;
  logic        req_b, we_b, busy_b, done_b, rwo_b, wfo_b, bro_b, err_b;
  logic [31:0] addr_b, wdata_b, rwd_b, bra_b;
  logic [4:0]  wro_b;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rc_a = 0, rc_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access dut_a (
    .clk(clk), .rst(rst), .state(state_a),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .write_reg_in(write_reg_in), .writef_in(writef_in),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .alu_result(alu_result),
    .branch_in(branch_in), .branch_addr_in(branch_addr_in),
    .dmem_req(req_a), .dmem_we(we_a), .dmem_addr(addr_a), .dmem_wdata(wdata_a),
    .dmem_ready(ready_a), .dmem_rvalid(rvalid_a), .dmem_rdata(rdata),
    .busy(busy_a), .done(done_a), .reg_write_out(rwo_a), .write_reg_out(wro_a),
    .writef_out(wfo_a), .reg_write_data(rwd_a), .branch_out(bro_a),
    .branch_addr_out(bra_a), .err(err_a)
  );

  mem_access #(.TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .state(state_b),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .write_reg_in(write_reg_in), .writef_in(writef_in),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .alu_result(alu_result),
    .branch_in(branch_in), .branch_addr_in(branch_addr_in),
    .dmem_req(req_b), .dmem_we(we_b), .dmem_addr(addr_b), .dmem_wdata(wdata_b),
    .dmem_ready(ready_b), .dmem_rvalid(rvalid_b), .dmem_rdata(rdata),
    .busy(busy_b), .done(done_b), .reg_write_out(rwo_b), .write_reg_out(wro_b),
    .writef_out(wfo_b), .reg_write_data(rwd_b), .branch_out(bro_b),
    .branch_addr_out(bra_b), .err(err_b)
  );

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic check_done(input string tag, input exp_t e, input int rc,
                            input logic rw, input logic [4:0] wreg, input logic wf,
                            input logic [31:0] data, input logic br,
                            input logic [31:0] braddr, input logic er);
    cmp({tag, "_done_cycle"}, cyc, e.done_cyc);
    cmp({tag, "_req_cycles"}, rc, e.reqs);
    cmp({tag, "_reg_write_out"}, {31'd0, rw}, {31'd0, e.rw});
    cmp({tag, "_write_reg_out"}, {27'd0, wreg}, {27'd0, e.wreg});
    cmp({tag, "_writef_out"}, {31'd0, wf}, {31'd0, e.wf});
    cmp({tag, "_reg_write_data"}, data, e.data);
    cmp({tag, "_branch_out"}, {31'd0, br}, {31'd0, e.br});
    cmp({tag, "_branch_addr_out"}, braddr, e.braddr);
    cmp({tag, "_err"}, {31'd0, er}, {31'd0, e.err});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!busy_a) rc_a = 0;
    else if (req_a) rc_a++;
    if (done_a) begin
      if (q_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_done: done=1 with no pending transaction (cycle %0d)", cyc);
      end else begin
        e = q_a.pop_front();
        check_done("a", e, rc_a, rwo_a, wro_a, wfo_a, rwd_a, bro_a, bra_a, err_a);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!busy_b) rc_b = 0;
    else if (req_b) rc_b++;
    if (done_b) begin
      if (q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_done: done=1 with no pending transaction (cycle %0d)", cyc);
      end else begin
        e = q_b.pop_front();
        check_done("b", e, rc_b, rwo_b, wro_b, wfo_b, rwd_b, bro_b, bra_b, err_b);
      end
    end
  end

  // Presents one instruction for a single cycle, then scrambles the inputs.
  task automatic issue(input bit to_b, input bit push,
                       input logic rd, input logic wr, input logic rw,
                       input logic [4:0] wreg, input logic wf,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] alu, input logic br, input logic [31:0] braddr,
                       input int lat, input int reqs, input logic [31:0] xdata,
                       input logic xrw, input logic xerr);
    exp_t e;
    @(negedge clk);
    mem_read_in = rd; mem_write_in = wr; reg_write_in = rw;
    write_reg_in = wreg; writef_in = wf; mem_addr = addr;
    mem_write_data = wdata; alu_result = alu; branch_in = br; branch_addr_in = braddr;
    e.done_cyc = cyc + lat; e.reqs = reqs; e.rw = xrw; e.wreg = wreg; e.wf = wf;
    e.data = xdata; e.br = br; e.braddr = braddr; e.err = xerr;
    if (to_b) state_b = 3'd3; else state_a = 3'd3;
    if (push) begin
      if (to_b) q_b.push_back(e); else q_a.push_back(e);
    end
    @(negedge clk);
    state_a = 3'd0; state_b = 3'd0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0;
    write_reg_in = 5'h1f; writef_in = 1'b0; mem_addr = 32'hFFFF_FFF0;
    mem_write_data = 32'hA5A5_A5A5; alu_result = 32'hDEAD_0000;
    branch_in = 1'b0; branch_addr_in = 32'hFFFF_0000;
  endtask

  task automatic check_zero_a(input string tag);
    cmp({tag, "_dmem_req"}, {31'd0, req_a}, 32'd0);
    cmp({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    cmp({tag, "_done"}, {31'd0, done_a}, 32'd0);
    cmp({tag, "_err"}, {31'd0, err_a}, 32'd0);
    cmp({tag, "_reg_write_data"}, rwd_a, 32'd0);
    cmp({tag, "_reg_write_out"}, {31'd0, rwo_a}, 32'd0);
    cmp({tag, "_write_reg_out"}, {27'd0, wro_a}, 32'd0);
    cmp({tag, "_branch_out"}, {31'd0, bro_a}, 32'd0);
    cmp({tag, "_branch_addr_out"}, bra_a, 32'd0);
    cmp({tag, "_dmem_addr"}, addr_a, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; state_a = 3'd0; state_b = 3'd0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0;
    write_reg_in = 5'd0; writef_in = 1'b0; mem_addr = 32'd0; mem_write_data = 32'd0;
    alu_result = 32'd0; branch_in = 1'b0; branch_addr_in = 32'd0;
    ready_a = 1'b1; rvalid_a = 1'b0; ready_b = 1'b0; rvalid_b = 1'b0; rdata = 32'd0;
    repeat (3) @(negedge clk);
    check_zero_a("reset");
    rst = 1'b0;

    // No access: done one cycle after start.
    issue(0, 1, 0, 0, 1, 5'd5, 0, 32'h0, 32'h0, 32'h1234, 0, 32'h0,
          1, 0, 32'h1234, 1, 0);
    repeat (3) @(negedge clk);
    cmp("hold_reg_write_data", rwd_a, 32'h1234);
    cmp("hold_write_reg_out", {27'd0, wro_a}, 32'd5);

    // Load 0x100, accepted immediately, rvalid two cycles after acceptance.
    issue(0, 1, 1, 0, 1, 5'd3, 1, 32'h100, 32'h0, 32'h77, 0, 32'h0,
          4, 1, 32'hDEAD_BEEF, 1, 0);
    cmp("load_dmem_req", {31'd0, req_a}, 32'd1);
    cmp("load_dmem_we", {31'd0, we_a}, 32'd0);
    cmp("load_dmem_addr", addr_a, 32'h100);
    rvalid_a = 1'b1; rdata = 32'h1234_5678;
    @(negedge clk); rvalid_a = 1'b0;
    @(negedge clk); rvalid_a = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk); rvalid_a = 1'b0;
    repeat (2) @(negedge clk);

    // Store with ready held low for three REQ cycles.
    ready_a = 1'b0;
    issue(0, 1, 0, 1, 1, 5'd7, 0, 32'h200, 32'h55AA_1234, 32'h200, 0, 32'h0,
          5, 4, 32'h200, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cmp("store_dmem_req", {31'd0, req_a}, 32'd1);
      cmp("store_dmem_we", {31'd0, we_a}, 32'd1);
      cmp("store_dmem_addr", addr_a, 32'h200);
      cmp("store_dmem_wdata", wdata_a, 32'h55AA_1234);
      if (i == 3) ready_a = 1'b1;
      else @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // Store accepted in the first REQ cycle, with a branch.
    issue(0, 1, 0, 1, 0, 5'd0, 0, 32'h300, 32'h9, 32'h300, 1, 32'h8000,
          2, 1, 32'h300, 0, 0);
    repeat (3) @(negedge clk);

    // Read and write together: read wins, err set.
    issue(0, 1, 1, 1, 1, 5'd9, 0, 32'h400, 32'h11, 32'h400, 0, 32'h0,
          3, 1, 32'h0BAD_F00D, 0, 1);
    cmp("both_dmem_we", {31'd0, we_a}, 32'd0);
    @(negedge clk); rvalid_a = 1'b1; rdata = 32'h0BAD_F00D;
    @(negedge clk); rvalid_a = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while waiting for read data; the late rvalid must be ignored.
    issue(0, 0, 1, 0, 1, 5'd6, 0, 32'h600, 32'h0, 32'h600, 1, 32'h60, 0, 0, 32'h0, 0, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_zero_a("rst_wait");
    rst = 1'b0; rvalid_a = 1'b1; rdata = 32'hFFFF_FFFF;
    @(negedge clk); rvalid_a = 1'b0;
    @(negedge clk);
    cmp("late_rvalid_busy", {31'd0, busy_a}, 32'd0);
    cmp("late_rvalid_reg_write_data", rwd_a, 32'd0);
    cmp("late_rvalid_err", {31'd0, err_a}, 32'd0);

    // TIMEOUT=4 instance with ready stuck low.
    issue(1, 1, 1, 0, 1, 5'd2, 0, 32'h500, 32'h0, 32'h500, 1, 32'h44,
          5, 4, 32'h0, 0, 1);
    repeat (6) @(negedge clk);
    cmp("timeout_req_dropped", {31'd0, req_b}, 32'd0);
    cmp("timeout_busy", {31'd0, busy_b}, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
    issue(0, 1, 1, 0, 1, 5'd4, 0, 32'h102, 32'h0, 32'h102, 0, 32'h0,
          1, 0, 32'h0, 0, 1);
    repeat (3) @(negedge clk);
`else
    issue(0, 1, 1, 0, 1, 5'd4, 0, 32'h102, 32'h0, 32'h102, 0, 32'h0,
          3, 1, 32'hCAFE_0001, 1, 0);
    cmp("unaligned_dmem_addr", addr_a, 32'h102);
    @(negedge clk); rvalid_a = 1'b1; rdata = 32'hCAFE_0001;
    @(negedge clk); rvalid_a = 1'b0;
    repeat (2) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    cmp("a_pending_at_end", q_a.size(), 32'd0);
    cmp("b_pending_at_end", q_b.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
